// File: rtl/router_pkt_gen_pkg.sv
// Shared types and helpers for the router packet generator: FSM state
// encoding, field widths and the router header packing rule.
package router_pkg;

  localparam int unsigned LEN_W = 6;
  localparam logic [1:0]  ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    HDR,
    PLD,
    PAR,
    GAP
  } state_e;

  // Router header byte: length in the upper six bits, destination below.
  function automatic logic [7:0] hdr(input logic [LEN_W-1:0] len,
                                     input logic [1:0]       dest);
    return {len, dest};
  endfunction

endpackage

// File: rtl/router_pkt_gen_if.sv
// Command/payload ingress and router-facing egress bundle for the packet
// generator. The master side is the upstream producer plus the router
// (which supplies busy); the slave side is the generator itself.
interface router_pkt_gen_if;
  import router_pkg::*;

  logic             start;
  logic [1:0]       dest;
  logic [LEN_W-1:0] len;
  logic [7:0]       pld_data;
  logic             pld_valid;
  logic             pld_ready;
  logic             busy;
  logic             inject_err;
  logic             pkt_valid;
  logic [7:0]       data_out;
  logic             gen_idle;
  logic             pkt_done;
  logic             cmd_reject;
  logic [15:0]      pkt_count;

  modport master (
    output start, dest, len, pld_data, pld_valid, busy, inject_err,
    input  pld_ready, pkt_valid, data_out, gen_idle, pkt_done, cmd_reject,
           pkt_count
  );

  modport slave (
    input  start, dest, len, pld_data, pld_valid, busy, inject_err,
    output pld_ready, pkt_valid, data_out, gen_idle, pkt_done, cmd_reject,
           pkt_count
  );

endinterface

// File: rtl/router_pkt_gen_buf.sv
// Payload buffer: MAX_LEN x 8 register array, one write port and one
// combinational read port. The data array is not reset; stale contents are
// never read because pointers restart with every packet.
module router_pkt_buf
  import router_pkg::*;
#(
  parameter int unsigned MAX_LEN = 63
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [LEN_W-1:0] wr_ptr,
  input  logic [7:0]       wr_data,
  input  logic [LEN_W-1:0] rd_ptr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem_q [MAX_LEN];

  // Store one payload byte per accepted handshake.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  // Combinational read so data_out follows rd_ptr in the same cycle.
  always_comb begin
    rd_data = mem_q[rd_ptr];
  end

endmodule

// File: rtl/router_pkt_gen.sv
// Router ingress packetizer: accepts a (dest, len) command, buffers len
// payload bytes, then emits header / payload / parity to the router while
// honouring busy, followed by a fixed inter-packet gap.
// Optional feature: ROUTER_PKT_GEN_ERR_INJ_EN enables parity corruption via
// inject_err captured with the command; otherwise inject_err has no load.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 63,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetn,
  router_pkt_gen_if.slave   bus
);

  localparam int unsigned      GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e           state_q, state_d;
  logic [1:0]       dest_q, dest_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       parity_q, parity_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             pkt_done_q, pkt_done_d;
  logic             cmd_reject_q, cmd_reject_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
  logic             inj_q, inj_d;
`endif

  logic       cmd_legal;
  logic       wr_en;
  logic [7:0] rd_data;
  logic [7:0] par_byte;

  router_pkt_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr_q),
    .wr_data (bus.pld_data),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Command legality check on the raw command inputs.
  always_comb begin
    cmd_legal = (bus.dest != ADDR_INVALID) && (bus.len != '0) &&
                (bus.len <= MAX_LEN_L);
  end

  // Next-state, buffer write and bookkeeping for the packet FSM.
  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    len_d        = len_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    parity_d     = parity_q;
    gap_cnt_d    = gap_cnt_q;
    pkt_done_d   = 1'b0;
    cmd_reject_d = 1'b0;
    pkt_count_d  = pkt_count_q;
    wr_en        = 1'b0;
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
    inj_d        = inj_q;
`endif

    if (bus.start && !((state_q == IDLE) && cmd_legal)) begin
      cmd_reject_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start && cmd_legal) begin
          dest_d   = bus.dest;
          len_d    = bus.len;
          parity_d = hdr(bus.len, bus.dest);
          wr_ptr_d = '0;
          rd_ptr_d = '0;
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
          inj_d    = bus.inject_err;
`endif
          state_d  = FILL;
        end
      end
      FILL: begin
        if (bus.pld_valid) begin
          wr_en    = 1'b1;
          parity_d = parity_q ^ bus.pld_data;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == len_q - 1'b1) begin
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (!bus.busy) begin
          state_d = PLD;
        end
      end
      PLD: begin
        if (!bus.busy) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == len_q - 1'b1) begin
            state_d = PAR;
          end
        end
      end
      PAR: begin
        if (!bus.busy) begin
          pkt_done_d  = 1'b1;
          pkt_count_d = pkt_count_q + 16'd1;
          gap_cnt_d   = '0;
          state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers; everything clears on reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      parity_q     <= '0;
      gap_cnt_q    <= '0;
      pkt_done_q   <= 1'b0;
      cmd_reject_q <= 1'b0;
      pkt_count_q  <= '0;
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
      inj_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      parity_q     <= parity_d;
      gap_cnt_q    <= gap_cnt_d;
      pkt_done_q   <= pkt_done_d;
      cmd_reject_q <= cmd_reject_d;
      pkt_count_q  <= pkt_count_d;
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
      inj_q        <= inj_d;
`endif
    end
  end

  // Parity byte as sent, optionally corrupted in its LSB.
  always_comb begin
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
    par_byte = parity_q ^ {7'b0, inj_q};
`else
    par_byte = parity_q;
`endif
  end

  // Outputs decoded from the registered state, so they hold while busy and
  // drop straight to their reset values when resetn is asserted.
  always_comb begin
    bus.pld_ready = (state_q == FILL);
    bus.gen_idle  = (state_q == IDLE);
    bus.pkt_valid = (state_q == HDR) || (state_q == PLD);
    case (state_q)
      HDR:     bus.data_out = hdr(len_q, dest_q);
      PLD:     bus.data_out = rd_data;
      PAR:     bus.data_out = par_byte;
      default: bus.data_out = '0;
    endcase
  end

  assign bus.pkt_done   = pkt_done_q;
  assign bus.cmd_reject = cmd_reject_q;
  assign bus.pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Directed plus randomized bench for router_pkt_gen. Expected router byte
// streams are built from the packet format rules (header, payload, XOR
// parity) and compared against the generator output cycle by cycle.
module tb_router_pkt_gen;

  localparam int unsigned MAX_LEN    = 63;
  localparam int unsigned GAP_CYCLES = 2;

  logic clock = 1'b0;
  logic resetn;
  int   checks    = 0;
  int   errors    = 0;
  int   exp_count = 0;

  logic [7:0] payload_q[$];
  logic [7:0] pkt_q[$];

  router_pkt_gen_if bus ();

  router_pkt_gen #(
    .MAX_LEN    (MAX_LEN),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected router stream for the current payload_q.
  task automatic build_pkt(input logic [1:0] d, input logic [5:0] n, input logic inj);
    logic [7:0] p;
    pkt_q.delete();
    p = {n, d};
    pkt_q.push_back(p);
    foreach (payload_q[k]) begin
      pkt_q.push_back(payload_q[k]);
      p = p ^ payload_q[k];
    end
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
    if (inj) p = p ^ 8'h01;
`else
    if (inj) p = p;
`endif
    pkt_q.push_back(p);
  endtask

  task automatic send_cmd(input logic [1:0] d, input logic [5:0] n, input logic inj);
    @(negedge clock);
    bus.start      = 1'b1;
    bus.dest       = d;
    bus.len        = n;
    bus.inject_err = inj;
    @(posedge clock);
    #1;
    bus.start      = 1'b0;
    bus.inject_err = 1'b0;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid.
  task automatic feed(input int mode, input int start_idx);
    int   idx = start_idx;
    int   cyc = 0;
    logic v, rdy;
    while (idx < payload_q.size() && cyc < 2000) begin
      @(negedge clock);
      rdy = bus.pld_ready;
      if (cyc == 0) chk("fill_ready", {31'b0, rdy}, 1);
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cyc % 2) == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.pld_valid = v;
      bus.pld_data  = v ? payload_q[idx] : 8'($urandom);
      bus.busy      = 1'($urandom);
      @(posedge clock);
      if (v && rdy) idx++;
      cyc++;
    end
    #1;
    bus.pld_valid = 1'b0;
    bus.busy      = 1'b0;
    chk("fill_count", idx, payload_q.size());
  endtask

  // bmode 0: never busy, 1: random busy, 2: busy hold_n cycles on byte hold_idx.
  task automatic receive(input int bmode, input int hold_idx, input int hold_n, input int stop_n);
    for (int i = 0; i < stop_n; i++) begin
      int held = 0;
      for (int c = 0; c < 8; c++) begin
        logic b;
        @(negedge clock);
        case (bmode)
          0:       b = 1'b0;
          1:       b = (held < 3) && ($urandom_range(0, 2) == 0);
          default: b = (i == hold_idx) && (held < hold_n);
        endcase
        bus.busy = b;
        chk($sformatf("data[%0d]", i), {24'b0, bus.data_out}, {24'b0, pkt_q[i]});
        chk($sformatf("pkt_valid[%0d]", i), {31'b0, bus.pkt_valid},
            (i < int'(pkt_q.size()) - 1) ? 1 : 0);
        if (i == 0 && c == 0) chk("ready_low", {31'b0, bus.pld_ready}, 0);
        @(posedge clock);
        if (!b) break;
        held++;
      end
    end
    #1;
    bus.busy = 1'b0;
  endtask

  task automatic post_pkt();
    int gap = 1;
    exp_count = (exp_count + 1) % 65536;
    @(negedge clock);
    chk("pkt_done", {31'b0, bus.pkt_done}, 1);
    chk("pkt_count", {16'b0, bus.pkt_count}, exp_count);
    chk("gap_pv", {31'b0, bus.pkt_valid}, 0);
    chk("gap_data", {24'b0, bus.data_out}, 0);
    while (!bus.gen_idle && gap < 50) begin
      @(posedge clock);
      @(negedge clock);
      if (!bus.gen_idle) gap++;
    end
    chk("gap_len", gap, GAP_CYCLES);
    chk("pkt_done_end", {31'b0, bus.pkt_done}, 0);
  endtask

  task automatic run_pkt(input logic [1:0] d, input logic [5:0] n, input logic inj,
                         input int fmode, input int bmode, input int hold_idx, input int hold_n);
    build_pkt(d, n, inj);
    send_cmd(d, n, inj);
    feed(fmode, 0);
    receive(bmode, hold_idx, hold_n, pkt_q.size());
    post_pkt();
  endtask

  task automatic reject(input logic [1:0] d, input logic [5:0] n);
    send_cmd(d, n, 1'b0);
    @(negedge clock);
    chk("rej_pulse", {31'b0, bus.cmd_reject}, 1);
    chk("rej_idle", {31'b0, bus.gen_idle}, 1);
    chk("rej_ready", {31'b0, bus.pld_ready}, 0);
    @(negedge clock);
    chk("rej_end", {31'b0, bus.cmd_reject}, 0);
    chk("rej_idle2", {31'b0, bus.gen_idle}, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_idle", {31'b0, bus.gen_idle}, 1);
    chk("rst_ready", {31'b0, bus.pld_ready}, 0);
    chk("rst_pv", {31'b0, bus.pkt_valid}, 0);
    chk("rst_data", {24'b0, bus.data_out}, 0);
    chk("rst_done", {31'b0, bus.pkt_done}, 0);
    chk("rst_reject", {31'b0, bus.cmd_reject}, 0);
    chk("rst_count", {16'b0, bus.pkt_count}, 0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.dest       = '0;
    bus.len        = '0;
    bus.pld_data   = '0;
    bus.pld_valid  = 1'b0;
    bus.busy       = 1'b0;
    bus.inject_err = 1'b0;
    resetn         = 1'b1;
    #2 resetn = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;

    // Basic packet: 0D 01 02 04 0A.
    payload_q = '{8'h01, 8'h02, 8'h04};
    run_pkt(2'd1, 6'd3, 1'b0, 0, 0, 0, 0);

    // Same packet with busy held 3 cycles on payload byte 02.
    run_pkt(2'd1, 6'd3, 1'b0, 0, 2, 2, 3);

    // Illegal commands.
    reject(2'd3, 6'd5);
    reject(2'd1, 6'd0);

    // start during FILL is refused and the packet in progress is unaffected.
    payload_q = '{8'h01, 8'h02, 8'h04};
    build_pkt(2'd1, 6'd3, 1'b0);
    send_cmd(2'd1, 6'd3, 1'b0);
    @(negedge clock);
    bus.pld_valid = 1'b1;
    bus.pld_data  = 8'h01;
    bus.start     = 1'b1;
    bus.dest      = 2'd0;
    bus.len       = 6'd2;
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
    bus.pld_valid = 1'b0;
    @(negedge clock);
    chk("fill_reject", {31'b0, bus.cmd_reject}, 1);
    chk("fill_not_idle", {31'b0, bus.gen_idle}, 0);
    feed(0, 1);
    receive(0, 0, 0, pkt_q.size());
    post_pkt();

    // Maximum length with pld_valid toggling.
    payload_q.delete();
    for (int k = 0; k < 63; k++) payload_q.push_back(8'(k));
    run_pkt(2'd2, 6'd63, 1'b0, 1, 0, 0, 0);

    // Randomized packets with random valid gaps and random busy.
    for (int t = 0; t < 6; t++) begin
      logic [1:0] d;
      logic [5:0] n;
      d = 2'($urandom_range(0, 2));
      n = 6'($urandom_range(1, MAX_LEN));
      payload_q.delete();
      for (int k = 0; k < int'(n); k++) payload_q.push_back(8'($urandom));
      run_pkt(d, n, 1'($urandom), 2, 1, 0, 0);
    end

    // Reset during payload byte 2.
    payload_q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    build_pkt(2'd2, 6'd4, 1'b0);
    send_cmd(2'd2, 6'd4, 1'b0);
    feed(0, 0);
    receive(0, 0, 0, 2);
    @(negedge clock);
    chk("pre_rst_data", {24'b0, bus.data_out}, {24'b0, pkt_q[2]});
    chk("pre_rst_pv", {31'b0, bus.pkt_valid}, 1);
    #1 resetn = 1'b0;
    #1 check_reset_outputs();
    exp_count = 0;
    @(posedge clock);
    #2 resetn = 1'b1;
    payload_q = '{8'h55};
    run_pkt(2'd0, 6'd1, 1'b0, 0, 0, 0, 0);

    // Parity corruption request on the basic packet.
    payload_q = '{8'h01, 8'h02, 8'h04};
    run_pkt(2'd1, 6'd3, 1'b1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
